// File: rtl/pwl_channel_scheduler_if.sv
// Host command/read-back bus for pwl_channel_scheduler.
// The host (master) issues {cmd,wdata} words under a valid/ready handshake
// and observes the result of the most recent READ on rd_valid/rd_data.
interface pwl_channel_scheduler_if;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [12:0] wdata;
    logic        cmd_ready;
    logic        rd_valid;
    logic [12:0] rd_data;

    modport master (
        output cmd_valid,
        output cmd,
        output wdata,
        input  cmd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  wdata,
        output cmd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/pwl_channel_scheduler.sv
// pwl_channel_scheduler: shares the 4-channel synth ALU and its per-channel
// register file between the round-robin time-slot sequencer and host register
// accesses. Host writes/reads are queued and committed in order, but never to
// the channel the ALU currently owns, so a channel is never torn mid-slot.
module pwl_channel_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int STEPS      = 8,
    parameter int STEP_W     = 3,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwl_channel_scheduler_if.slave host,
    output logic                  alu_en_o,
    output logic [CH_W-1:0]       alu_ch_o,
    output logic [STEP_W-1:0]     alu_step_o,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    output logic [CH_W-1:0]       reg_ch_o,
    output logic [ADDR_W-1:0]     reg_addr_o,
    output logic [12:0]           reg_wdata_o,
    input  logic [12:0]           reg_rdata_i
);

    localparam int DATA_W  = 13;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + CH_W + ADDR_W + DATA_W;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_SEL   = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_WRINC = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;
    localparam logic [2:0] CMD_RUN   = 3'd5;

    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    // Sequencer state
    logic              run_q, run_d;
    logic [CH_W-1:0]   alu_ch_q, alu_ch_d;
    logic [STEP_W-1:0] alu_step_q, alu_step_d;

    // Host selection registers
    logic [CH_W-1:0]   sel_ch_q, sel_ch_d;
    logic [ADDR_W-1:0] sel_addr_q, sel_addr_d;

    // Read-back state
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Op queue: entry = {is_read, ch, addr, data}
    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;

    logic               accept;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_rd;
    logic [CH_W-1:0]    head_ch;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               head_eligible;

    // Every command, including SEL/RUN/NOP, waits for queue space so none
    // can overtake queued ops while the queue is full.
    assign host.cmd_ready = (count_q != FIFO_FULL);
    assign accept         = host.cmd_valid && host.cmd_ready;

    assign fifo_empty = (count_q == '0);
    assign head_entry = fifo_q[rd_ptr_q];
    assign {head_rd, head_ch, head_addr, head_data} = head_entry;

    // The head may commit unless a read result is still outstanding or its
    // channel is the one the running ALU is stepping through.
    assign head_eligible = !fifo_empty && !rd_pend_q &&
                           (!run_q || (head_ch != alu_ch_q));
    assign pop           = head_eligible;

    assign reg_we_o    = head_eligible && !head_rd;
    assign reg_re_o    = head_eligible && head_rd;
    assign reg_ch_o    = fifo_empty ? '0 : head_ch;
    assign reg_addr_o  = fifo_empty ? '0 : head_addr;
    assign reg_wdata_o = fifo_empty ? '0 : head_data;

    assign alu_en_o      = run_q;
    assign alu_ch_o      = alu_ch_q;
    assign alu_step_o    = alu_step_q;
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rd_data_q;

    // Decode accepted WRITE/WRINC/READ commands into queue entries
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            case (host.cmd)
                CMD_WRITE, CMD_WRINC: begin
                    push       = 1'b1;
                    push_entry = {1'b0, sel_ch_q, sel_addr_q, host.wdata};
                end
                CMD_READ: begin
                    push       = 1'b1;
                    push_entry = {1'b1, sel_ch_q, sel_addr_q, DATA_W'(0)};
                end
                default: ;
            endcase
        end
    end

    // Round-robin sequencer next state; a RUN command overrides stepping
    always_comb begin
        run_d      = run_q;
        alu_ch_d   = alu_ch_q;
        alu_step_d = alu_step_q;
        if (run_q) begin
            if (alu_step_q == LAST_STEP) begin
                alu_step_d = '0;
                alu_ch_d   = (alu_ch_q == LAST_CH) ? '0 : alu_ch_q + CH_W'(1);
            end else begin
                alu_step_d = alu_step_q + STEP_W'(1);
            end
        end
        if (accept && (host.cmd == CMD_RUN)) begin
            run_d = host.wdata[0];
            if (host.wdata[1]) begin
                alu_ch_d   = '0;
                alu_step_d = '0;
            end
        end
    end

    // Host channel/address selection, with auto-increment for WRINC
    always_comb begin
        sel_ch_d   = sel_ch_q;
        sel_addr_d = sel_addr_q;
        if (accept) begin
            case (host.cmd)
                CMD_SEL: begin
                    sel_addr_d = host.wdata[ADDR_W-1:0];
                    sel_ch_d   = host.wdata[ADDR_W+CH_W-1:ADDR_W];
                end
                CMD_WRINC: sel_addr_d = sel_addr_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Read result capture one cycle after the register-file read strobe
    always_comb begin
        rd_pend_d  = rd_pend_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (rd_pend_q) begin
            rd_data_d  = reg_rdata_i;
            rd_valid_d = 1'b1;
            rd_pend_d  = 1'b0;
        end
        if (reg_re_o) begin
            rd_pend_d = 1'b1;
        end
        if (accept && (host.cmd == CMD_READ)) begin
            rd_valid_d = 1'b0;
        end
    end

    // Control registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            alu_ch_q   <= '0;
            alu_step_q <= '0;
            sel_ch_q   <= '0;
            sel_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            run_q      <= run_d;
            alu_ch_q   <= alu_ch_d;
            alu_step_q <= alu_step_d;
            sel_ch_q   <= sel_ch_d;
            sel_addr_q <= sel_addr_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_pwl_channel_scheduler.sv
// Directed self-checking bench for pwl_channel_scheduler.
// Inputs change 1ns after the rising edge and outputs are sampled there too,
// so every check sees the state registered by the preceding edge.
module tb_pwl_channel_scheduler;

    localparam logic [2:0] CMD_SEL   = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_WRINC = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;
    localparam logic [2:0] CMD_RUN   = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        aluEn;
    logic [1:0]  aluCh;
    logic [2:0]  aluStep;
    logic        regWe;
    logic        regRe;
    logic [1:0]  regCh;
    logic [3:0]  regAddr;
    logic [12:0] regWdata;
    logic [12:0] regRdata;

    int vecCount;
    int missCount;

    pwl_channel_scheduler_if hostIf ();

    pwl_channel_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (hostIf),
        .alu_en_o    (aluEn),
        .alu_ch_o    (aluCh),
        .alu_step_o  (aluStep),
        .reg_we_o    (regWe),
        .reg_re_o    (regRe),
        .reg_ch_o    (regCh),
        .reg_addr_o  (regAddr),
        .reg_wdata_o (regWdata),
        .reg_rdata_i (regRdata)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one command for exactly one edge, then return the bus to idle
    task automatic applyStimulus(input logic [2:0] cmd, input logic [12:0] wdata);
        hostIf.cmd_valid = 1'b1;
        hostIf.cmd       = cmd;
        hostIf.wdata     = wdata;
        @(posedge clk);
        #1;
        hostIf.cmd_valid = 1'b0;
        hostIf.cmd       = 3'd0;
        hostIf.wdata     = 13'd0;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        vecCount         = 0;
        missCount        = 0;
        rst_n            = 1'b0;
        regRdata         = 13'd0;
        hostIf.cmd_valid = 1'b0;
        hostIf.cmd       = 3'd0;
        hostIf.wdata     = 13'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", hostIf.cmd_ready, 1);
        checkOutput("rst_alu_en", aluEn, 0);
        checkOutput("rst_reg_we", regWe, 0);
        checkOutput("rst_rd_valid", hostIf.rd_valid, 0);
        checkOutput("rst_reg_wdata", regWdata, 0);
        rst_n = 1'b1;
        stepClock();

        // 1: SEL ch2/addr5 then WRITE commits the next cycle
        applyStimulus(CMD_SEL, 13'h025);
        checkOutput("t1_no_we_after_sel", regWe, 0);
        applyStimulus(CMD_WRITE, 13'h1ABC);
        checkOutput("t1_we", regWe, 1);
        checkOutput("t1_ch", regCh, 2);
        checkOutput("t1_addr", regAddr, 5);
        checkOutput("t1_wdata", regWdata, 13'h1ABC);
        checkOutput("t1_ready", hostIf.cmd_ready, 1);
        stepClock();
        checkOutput("t1_we_drop", regWe, 0);

        // 2: write to ch0 while the ALU owns ch0 waits for the slot to end
        applyStimulus(CMD_SEL, 13'h007);
        applyStimulus(CMD_RUN, 13'h003);
        checkOutput("t2_alu_en", aluEn, 1);
        checkOutput("t2_sync_step", aluStep, 0);
        applyStimulus(CMD_WRITE, 13'h0ABC);
        checkOutput("t2_blocked_step1", regWe, 0);
        for (int i = 2; i <= 7; i++) begin
            stepClock();
            checkOutput("t2_blocked", regWe, 0);
        end
        stepClock();
        checkOutput("t2_alu_ch1", aluCh, 1);
        checkOutput("t2_we", regWe, 1);
        checkOutput("t2_ch", regCh, 0);
        checkOutput("t2_addr", regAddr, 7);
        checkOutput("t2_wdata", regWdata, 13'h0ABC);

        // 3: sequencer walks 0,1,2,3,0 with 8 steps per channel
        applyStimulus(CMD_RUN, 13'h003);
        checkOutput("t3_ch0", aluCh, 0);
        checkOutput("t3_step0", aluStep, 0);
        for (int i = 1; i <= 40; i++) begin
            stepClock();
            checkOutput("t3_ch", aluCh, (i / 8) % 4);
            checkOutput("t3_step", aluStep, i % 8);
        end

        // 4: WRINC from addr 15 wraps to 0 and keeps the channel
        applyStimulus(CMD_RUN, 13'h000);
        checkOutput("t4_alu_off", aluEn, 0);
        applyStimulus(CMD_SEL, 13'h01F);
        applyStimulus(CMD_WRINC, 13'h0101);
        checkOutput("t4_we0", regWe, 1);
        checkOutput("t4_addr0", regAddr, 15);
        checkOutput("t4_ch0", regCh, 1);
        applyStimulus(CMD_WRINC, 13'h0202);
        checkOutput("t4_addr1", regAddr, 0);
        checkOutput("t4_wdata1", regWdata, 13'h0202);
        applyStimulus(CMD_WRINC, 13'h0303);
        checkOutput("t4_addr2", regAddr, 1);
        applyStimulus(CMD_WRITE, 13'h0404);
        checkOutput("t4_addr3", regAddr, 2);
        checkOutput("t4_ch3", regCh, 1);
        stepClock();
        checkOutput("t4_idle", regWe, 0);

        // 5: fill the queue behind the busy channel, hold an extra command
        applyStimulus(CMD_SEL, 13'h000);
        applyStimulus(CMD_RUN, 13'h003);
        applyStimulus(CMD_WRITE, 13'h1001);
        checkOutput("t5_blocked", regWe, 0);
        applyStimulus(CMD_WRITE, 13'h1002);
        applyStimulus(CMD_WRITE, 13'h1003);
        applyStimulus(CMD_WRITE, 13'h1004);
        checkOutput("t5_full", hostIf.cmd_ready, 0);
        hostIf.cmd_valid = 1'b1;
        hostIf.cmd       = CMD_WRITE;
        hostIf.wdata     = 13'h1555;
        for (int i = 5; i <= 7; i++) begin
            stepClock();
            checkOutput("t5_still_full", hostIf.cmd_ready, 0);
            checkOutput("t5_still_blocked", regWe, 0);
        end
        stepClock();
        checkOutput("t5_pop_we", regWe, 1);
        checkOutput("t5_pop_data", regWdata, 13'h1001);
        checkOutput("t5_pop_ready", hostIf.cmd_ready, 0);
        stepClock();
        checkOutput("t5_ready_back", hostIf.cmd_ready, 1);
        checkOutput("t5_data2", regWdata, 13'h1002);
        stepClock();
        hostIf.cmd_valid = 1'b0;
        hostIf.cmd       = 3'd0;
        hostIf.wdata     = 13'd0;
        checkOutput("t5_data3", regWdata, 13'h1003);
        stepClock();
        checkOutput("t5_data4", regWdata, 13'h1004);
        stepClock();
        checkOutput("t5_data_extra", regWdata, 13'h1555);
        checkOutput("t5_we_extra", regWe, 1);
        stepClock();
        checkOutput("t5_drained", regWe, 0);

        // 6: READ ch1/addr3 returns reg_rdata one cycle after the strobe
        applyStimulus(CMD_RUN, 13'h000);
        applyStimulus(CMD_SEL, 13'h013);
        regRdata = 13'h0777;
        applyStimulus(CMD_READ, 13'h000);
        checkOutput("t6_re", regRe, 1);
        checkOutput("t6_we_low", regWe, 0);
        checkOutput("t6_ch", regCh, 1);
        checkOutput("t6_addr", regAddr, 3);
        stepClock();
        checkOutput("t6_re_once", regRe, 0);
        checkOutput("t6_not_yet", hostIf.rd_valid, 0);
        stepClock();
        regRdata = 13'h0123;
        checkOutput("t6_rd_valid", hostIf.rd_valid, 1);
        checkOutput("t6_rd_data", hostIf.rd_data, 13'h0777);
        stepClock();
        checkOutput("t6_rd_hold", hostIf.rd_data, 13'h0777);

        // 6b: asynchronous reset with two blocked ops queued
        applyStimulus(CMD_SEL, 13'h000);
        applyStimulus(CMD_RUN, 13'h003);
        applyStimulus(CMD_WRITE, 13'h0111);
        applyStimulus(CMD_WRITE, 13'h0222);
        checkOutput("t6_pre_wdata", regWdata, 13'h0111);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_alu_en", aluEn, 0);
        checkOutput("t6_async_wdata", regWdata, 0);
        checkOutput("t6_async_rd_valid", hostIf.rd_valid, 0);
        checkOutput("t6_async_rd_data", hostIf.rd_data, 0);
        checkOutput("t6_async_ready", hostIf.cmd_ready, 1);
        #2;
        rst_n = 1'b1;
        stepClock();
        checkOutput("t6_dropped_we", regWe, 0);
        checkOutput("t6_dropped_wdata", regWdata, 0);
        checkOutput("t6_step_held", aluStep, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
